// File: rtl/montprod_arb.sv
// Two-client round-robin arbiter and sequencer for one shared montprod core.
// The core's reset_n is driven from ~reset at the top level, outside this block.
module montprod_arb #(
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  len0,
    input  logic [7:0]  len1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        err,
    output logic [7:0]  opa_addr,
    output logic [7:0]  opb_addr,
    output logic [7:0]  opm_addr,
    input  logic [31:0] opa_data0,
    input  logic [31:0] opa_data1,
    input  logic [31:0] opb_data0,
    input  logic [31:0] opb_data1,
    input  logic [31:0] opm_data0,
    input  logic [31:0] opm_data1,
    output logic [7:0]  result_addr,
    output logic [31:0] result_data,
    output logic        result_we0,
    output logic        result_we1,
    output logic        mp_calculate,
    output logic [7:0]  mp_length,
    input  logic        mp_ready,
    input  logic [7:0]  mp_opa_addr,
    input  logic [7:0]  mp_opb_addr,
    input  logic [7:0]  mp_opm_addr,
    output logic [31:0] mp_opa_data,
    output logic [31:0] mp_opb_data,
    output logic [31:0] mp_opm_data,
    input  logic [7:0]  mp_result_addr,
    input  logic [31:0] mp_result_data,
    input  logic        mp_result_we
);

    localparam int unsigned CNT_W   = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam int unsigned CNT_MAX = (BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic             last_q, last_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic             err_q, err_d;
    logic             calc_q, calc_d;
    logic [7:0]       len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pick;
    logic [7:0]       pick_len;

    // State and registered outputs; reset leaves client 0 first in line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err_q   <= 1'b0;
            calc_q  <= 1'b0;
            len_q   <= 8'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            err_q   <= err_d;
            calc_q  <= calc_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output decode; done/err/calculate are one-cycle pulses.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        last_d   = last_q;
        gnt0_d   = gnt0_q;
        gnt1_d   = gnt1_q;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        err_d    = 1'b0;
        calc_d   = 1'b0;
        len_d    = len_q;
        cnt_d    = cnt_q;
        pick     = (req0 && req1) ? ~last_q : req1;
        pick_len = pick ? len1 : len0;

        case (state_q)
            S_IDLE: begin
                gnt0_d = 1'b0;
                gnt1_d = 1'b0;
                if (req0 || req1) begin
                    sel_d  = pick;
                    last_d = pick;
                    len_d  = pick_len;
                    gnt0_d = ~pick;
                    gnt1_d = pick;
                    if (pick_len == 8'd0) begin
                        state_d = S_DONE;
                        done0_d = ~pick;
                        done1_d = pick;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_START;
                        calc_d  = 1'b1;
                    end
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!mp_ready) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == CNT_W'(CNT_MAX)) begin
                    state_d = S_DONE;
                    done0_d = ~sel_q;
                    done1_d = sel_q;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (mp_ready) begin
                    state_d = S_DONE;
                    done0_d = ~sel_q;
                    done1_d = sel_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign gnt0         = gnt0_q;
    assign gnt1         = gnt1_q;
    assign done0        = done0_q;
    assign done1        = done1_q;
    assign err          = err_q;
    assign mp_calculate = calc_q;
    assign mp_length    = len_q;

    // Core address/result paths broadcast to both clients; only the granted client may write.
    assign opa_addr    = mp_opa_addr;
    assign opb_addr    = mp_opb_addr;
    assign opm_addr    = mp_opm_addr;
    assign result_addr = mp_result_addr;
    assign result_data = mp_result_data;
    assign result_we0  = mp_result_we & gnt0_q;
    assign result_we1  = mp_result_we & gnt1_q;

    // Operand read data follows the registered select, stable for the whole operation.
    assign mp_opa_data = sel_q ? opa_data1 : opa_data0;
    assign mp_opb_data = sel_q ? opb_data1 : opb_data0;
    assign mp_opm_data = sel_q ? opm_data1 : opm_data0;

endmodule

// File: tb/tb_montprod_arb.sv
// Directed bench for montprod_arb with client memories and a one-word montprod core model.
module tb_montprod_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [7:0]  len0, len1;
    logic        gnt0, gnt1, done0, done1, err;
    logic [7:0]  opa_addr, opb_addr, opm_addr;
    logic [31:0] opa_data0, opa_data1, opb_data0, opb_data1, opm_data0, opm_data1;
    logic [7:0]  result_addr;
    logic [31:0] result_data;
    logic        result_we0, result_we1;
    logic        mp_calculate;
    logic [7:0]  mp_length;
    logic        mp_ready;
    logic [7:0]  mp_opa_addr, mp_opb_addr, mp_opm_addr;
    logic [31:0] mp_opa_data, mp_opb_data, mp_opm_data;
    logic [7:0]  mp_result_addr;
    logic [31:0] mp_result_data;
    logic        mp_result_we;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    montprod_arb #(.BUSY_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .len0(len0), .len1(len1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err),
        .opa_addr(opa_addr), .opb_addr(opb_addr), .opm_addr(opm_addr),
        .opa_data0(opa_data0), .opa_data1(opa_data1),
        .opb_data0(opb_data0), .opb_data1(opb_data1),
        .opm_data0(opm_data0), .opm_data1(opm_data1),
        .result_addr(result_addr), .result_data(result_data),
        .result_we0(result_we0), .result_we1(result_we1),
        .mp_calculate(mp_calculate), .mp_length(mp_length), .mp_ready(mp_ready),
        .mp_opa_addr(mp_opa_addr), .mp_opb_addr(mp_opb_addr), .mp_opm_addr(mp_opm_addr),
        .mp_opa_data(mp_opa_data), .mp_opb_data(mp_opb_data), .mp_opm_data(mp_opm_data),
        .mp_result_addr(mp_result_addr), .mp_result_data(mp_result_data),
        .mp_result_we(mp_result_we)
    );

    // Client operand memories (registered read) and result memories.
    logic [31:0] a0 [256], b0 [256], m0 [256], a1 [256], b1 [256], m1 [256];
    logic [31:0] r0 [256], r1 [256];

    always @(posedge clk) begin
        opa_data0 <= a0[opa_addr];
        opb_data0 <= b0[opb_addr];
        opm_data0 <= m0[opm_addr];
        opa_data1 <= a1[opa_addr];
        opb_data1 <= b1[opb_addr];
        opm_data1 <= m1[opm_addr];
        if (result_we0) r0[result_addr] <= result_data;
        if (result_we1) r1[result_addr] <= result_data;
    end

    // Bit-serial Montgomery product a*b*2^-32 mod m for one 32-bit word.
    function automatic logic [31:0] mont1(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] m);
        logic [33:0] t;
        t = 34'd0;
        for (int i = 0; i < 32; i++) begin
            if (a[i]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, m};
            t = t >> 1;
        end
        if (t >= {2'b00, m}) t = t - {2'b00, m};
        return t[31:0];
    endfunction

    // Core model: busy the cycle after calculate, reads word 0, writes, then ready again.
    typedef enum logic [1:0] {C_IDLE, C_READ, C_CALC, C_WRITE} core_st_t;
    core_st_t cst;
    logic     hold_busy;

    always @(posedge clk) begin
        if (reset) begin
            cst            <= C_IDLE;
            mp_ready       <= 1'b1;
            mp_result_we   <= 1'b0;
            mp_result_addr <= 8'd0;
            mp_result_data <= 32'd0;
            mp_opa_addr    <= 8'd0;
            mp_opb_addr    <= 8'd0;
            mp_opm_addr    <= 8'd0;
        end else begin
            case (cst)
                C_IDLE: begin
                    mp_result_we <= 1'b0;
                    if (mp_calculate && !hold_busy) begin
                        mp_ready <= 1'b0;
                        cst      <= C_READ;
                    end
                end
                C_READ: cst <= C_CALC;
                C_CALC: begin
                    mp_result_data <= mont1(mp_opa_data, mp_opb_data, mp_opm_data);
                    mp_result_addr <= 8'd0;
                    mp_result_we   <= 1'b1;
                    cst            <= C_WRITE;
                end
                default: begin
                    mp_result_we <= 1'b0;
                    mp_ready     <= 1'b1;
                    cst          <= C_IDLE;
                end
            endcase
        end
    end

    // Event counters and grant-order log, sampled at the active edge.
    int   calc_cnt = 0, we0_cnt = 0, we1_cnt = 0, both_cnt = 0, done_cnt = 0;
    int   gnt_log [64];
    int   gnt_n = 0;
    logic g0_prev = 1'b0, g1_prev = 1'b0;

    always @(posedge clk) begin
        if (mp_calculate) calc_cnt <= calc_cnt + 1;
        if (result_we0) we0_cnt <= we0_cnt + 1;
        if (result_we1) we1_cnt <= we1_cnt + 1;
        if (gnt0 && gnt1) both_cnt <= both_cnt + 1;
        if (done0 || done1) done_cnt <= done_cnt + 1;
        if (gnt0 && !g0_prev) begin
            gnt_log[gnt_n] <= 0;
            gnt_n          <= gnt_n + 1;
        end else if (gnt1 && !g1_prev) begin
            gnt_log[gnt_n] <= 1;
            gnt_n          <= gnt_n + 1;
        end
        g0_prev <= gnt0;
        g1_prev <= gnt1;
    end

    // Waits up to budget cycles for a done pulse; d0/d1 stay 0 if none arrives.
    task automatic wait_done(input int budget, output int cyc, output logic d0,
                             output logic d1, output logic e);
        cyc = budget;
        d0  = 1'b0;
        d1  = 1'b0;
        e   = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done0 || done1) begin
                cyc = i + 1;
                d0  = done0;
                d1  = done1;
                e   = err;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] outs;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        outs = {gnt0, gnt1, done0, done1, err, mp_calculate, result_we0, result_we1};
        checks++;
        if (outs !== 8'h00) begin
            errors++;
            $display("FAIL reset_outs: got %b expected 00000000", outs);
        end
        checks++;
        if (mp_length !== 8'd0) begin
            errors++;
            $display("FAIL reset_len: got %0h expected 0", mp_length);
        end
        reset = 1'b0;
        @(negedge clk);
        outs = {gnt0, gnt1, done0, done1, err, mp_calculate, result_we0, result_we1};
        checks++;
        if (outs !== 8'h00) begin
            errors++;
            $display("FAIL idle_outs: got %b expected 00000000", outs);
        end
    endtask

    task automatic test_single();
        int   c0, w0, w1, cyc;
        logic d0, d1, e;
        a0[0] = 32'hb; b0[0] = 32'h2; m0[0] = 32'h11;
        c0 = calc_cnt; w0 = we0_cnt; w1 = we1_cnt;
        len0 = 8'd1;
        req0 = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, mp_calculate} !== 3'b101) begin
            errors++;
            $display("FAIL single_grant: got gnt0,gnt1,calc=%b expected 101", {gnt0, gnt1, mp_calculate});
        end
        checks++;
        if (mp_length !== 8'd1) begin
            errors++;
            $display("FAIL single_len: got %0h expected 1", mp_length);
        end
        @(negedge clk);
        checks++;
        if ({gnt0, mp_calculate} !== 2'b10) begin
            errors++;
            $display("FAIL single_calc_once: got gnt0,calc=%b expected 10", {gnt0, mp_calculate});
        end
        wait_done(20, cyc, d0, d1, e);
        checks++;
        if ({d0, d1, e, gnt0} !== 4'b1001) begin
            errors++;
            $display("FAIL single_done: got done0,done1,err,gnt0=%b expected 1001", {d0, d1, e, gnt0});
        end
        req0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt0, done0} !== 2'b00) begin
            errors++;
            $display("FAIL single_release: got gnt0,done0=%b expected 00", {gnt0, done0});
        end
        @(negedge clk);
        checks++;
        if (r0[0] !== 32'h5) begin
            errors++;
            $display("FAIL single_result: got %0h expected 5", r0[0]);
        end
        checks++;
        if ({calc_cnt - c0, we0_cnt - w0, we1_cnt - w1} !== {32'd1, 32'd1, 32'd0}) begin
            errors++;
            $display("FAIL single_counts: got calc=%0d we0=%0d we1=%0d expected 1 1 0",
                     calc_cnt - c0, we0_cnt - w0, we1_cnt - w1);
        end
    endtask

    task automatic test_simultaneous();
        int   cyc;
        logic d0, d1, e;
        pulse_reset();
        a1[0] = 32'h7; b1[0] = 32'h9; m1[0] = 32'h13;
        len0 = 8'd1; len1 = 8'd1;
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL sim_first_grant: got gnt0,gnt1=%b expected 10", {gnt0, gnt1});
        end
        wait_done(20, cyc, d0, d1, e);
        checks++;
        if ({d0, d1, e} !== 3'b100) begin
            errors++;
            $display("FAIL sim_done0: got done0,done1,err=%b expected 100", {d0, d1, e});
        end
        req0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1} !== 2'b00) begin
            errors++;
            $display("FAIL sim_idle_gap: got gnt0,gnt1=%b expected 00", {gnt0, gnt1});
        end
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1} !== 2'b01) begin
            errors++;
            $display("FAIL sim_second_grant: got gnt0,gnt1=%b expected 01", {gnt0, gnt1});
        end
        wait_done(20, cyc, d0, d1, e);
        checks++;
        if ({d0, d1, e} !== 3'b010) begin
            errors++;
            $display("FAIL sim_done1: got done0,done1,err=%b expected 010", {d0, d1, e});
        end
        req1 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (r1[0] !== 32'h1) begin
            errors++;
            $display("FAIL sim_result1: got %0h expected 1", r1[0]);
        end
    endtask

    task automatic test_back_to_back();
        int   base, both0, cyc;
        int   exp_seq [4];
        logic d0, d1, e;
        exp_seq = '{0, 1, 0, 1};
        base = gnt_n; both0 = both_cnt;
        len0 = 8'd1; len1 = 8'd1;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_done(30, cyc, d0, d1, e);
            checks++;
            if ({d1, d0} !== ((exp_seq[k] == 1) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL b2b_done_%0d: got done1,done0=%b expected client %0d", k, {d1, d0}, exp_seq[k]);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (gnt_n - base !== 4) begin
            errors++;
            $display("FAIL b2b_grant_count: got %0d expected 4", gnt_n - base);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (gnt_log[base + k] !== exp_seq[k]) begin
                errors++;
                $display("FAIL b2b_order_%0d: got client %0d expected %0d", k, gnt_log[base + k], exp_seq[k]);
            end
        end
        checks++;
        if (both_cnt - both0 !== 0) begin
            errors++;
            $display("FAIL b2b_overlap: got %0d cycles with both gnt expected 0", both_cnt - both0);
        end
    endtask

    task automatic test_len0();
        int c0;
        c0 = calc_cnt;
        len1 = 8'd0;
        req1 = 1'b1;
        @(negedge clk);
        checks++;
        if ({done1, err, gnt1, done0, gnt0, mp_calculate} !== 6'b111000) begin
            errors++;
            $display("FAIL len0_done: got done1,err,gnt1,done0,gnt0,calc=%b expected 111000",
                     {done1, err, gnt1, done0, gnt0, mp_calculate});
        end
        req1 = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt1, done1, err} !== 3'b000) begin
            errors++;
            $display("FAIL len0_release: got gnt1,done1,err=%b expected 000", {gnt1, done1, err});
        end
        repeat (2) @(negedge clk);
        checks++;
        if (calc_cnt - c0 !== 0) begin
            errors++;
            $display("FAIL len0_no_calc: got %0d calculate pulses expected 0", calc_cnt - c0);
        end
        len1 = 8'd1;
    endtask

    task automatic test_timeout();
        int   cyc;
        logic d0, d1, e;
        hold_busy = 1'b1;
        len0 = 8'd1;
        req0 = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt0, mp_calculate} !== 2'b11) begin
            errors++;
            $display("FAIL to_grant: got gnt0,calc=%b expected 11", {gnt0, mp_calculate});
        end
        wait_done(20, cyc, d0, d1, e);
        checks++;
        if ({d0, d1, e} !== 3'b101) begin
            errors++;
            $display("FAIL to_done: got done0,done1,err=%b expected 101", {d0, d1, e});
        end
        checks++;
        if (cyc !== 5) begin
            errors++;
            $display("FAIL to_latency: got done %0d cycles after start expected 5", cyc);
        end
        req0 = 1'b0;
        hold_busy = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int   dn, w0, cyc;
        logic d0, d1, e;
        logic [8:0] outs;
        a0[0] = 32'h3; b0[0] = 32'h2; m0[0] = 32'h11;
        len0 = 8'd1;
        req0 = 1'b1;
        repeat (3) @(negedge clk);
        dn = done_cnt; w0 = we0_cnt;
        reset = 1'b1;
        req0  = 1'b0;
        @(negedge clk);
        outs = {gnt0, gnt1, done0, done1, err, mp_calculate, result_we0, result_we1, |mp_length};
        checks++;
        if (outs !== 9'h000) begin
            errors++;
            $display("FAIL rst_mid_outs: got %b expected 000000000", outs);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({done_cnt - dn, we0_cnt - w0} !== {32'd0, 32'd0}) begin
            errors++;
            $display("FAIL rst_mid_no_done: got done=%0d we0=%0d expected 0 0", done_cnt - dn, we0_cnt - w0);
        end
        len0 = 8'd1; len1 = 8'd1;
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL rst_mid_priority: got gnt0,gnt1=%b expected 10", {gnt0, gnt1});
        end
        wait_done(20, cyc, d0, d1, e);
        checks++;
        if ({d0, d1, e} !== 3'b100) begin
            errors++;
            $display("FAIL rst_mid_done: got done0,done1,err=%b expected 100", {d0, d1, e});
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (r0[0] !== 32'h6) begin
            errors++;
            $display("FAIL rst_mid_result: got %0h expected 6", r0[0]);
        end
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        len0 = 8'd0; len1 = 8'd0;
        hold_busy = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_back_to_back();
        test_len0();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
